// File: rtl/lsu_sequencer_pkg.sv
// Shared encodings for the load/store sequencer: access lengths, FSM states,
// counter sizing and the captured control fields of an accepted request.
package lsu_sequencer_pkg;

  // Width of the read-latency counter; bounds READ_LATENCY to 1..15.
  localparam int CNT_W            = 4;
  localparam int MAX_READ_LATENCY = (1 << CNT_W) - 1;

  // Access size encoding shared with memoryController.
  typedef enum logic [1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_RSVD = 2'd2,
    LEN_WORD = 2'd3
  } len_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Control fields captured at accept; they drive memLength/memUnsigned.
  typedef struct packed {
    logic [1:0] length;
    logic       is_unsigned;
  } req_ctl_t;

  // Natural alignment: halves on even addresses, words on 4-byte boundaries.
  function automatic logic misaligned(input logic [1:0] addr_lo,
                                      input logic [1:0] len);
    case (len_e'(len))
      LEN_HALF: return addr_lo[0];
      LEN_WORD: return |addr_lo;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Request, response and memoryController-facing signals of the sequencer.
// slave is the sequencer's view; master is the execute/memory side.
interface lsu_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  // execute-stage request
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqStore;
  logic                  reqLoad;
  logic [DATA_WIDTH-1:0] reqAddress;
  logic [DATA_WIDTH-1:0] reqData;
  logic [1:0]            reqLength;
  logic                  reqUnsigned;
  // completion
  logic                  respValid;
  logic [DATA_WIDTH-1:0] respData;
  logic                  respFault;
  // memoryController drive
  logic [DATA_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic [1:0]            memLength;
  logic                  memStore;
  logic                  memLoad;
  logic                  memUnsigned;
  logic [DATA_WIDTH-1:0] memReadData;

  modport slave (
    input  reqValid, reqStore, reqLoad, reqAddress, reqData, reqLength,
           reqUnsigned, memReadData,
    output reqReady, respValid, respData, respFault, memAddress,
           memWriteData, memLength, memStore, memLoad, memUnsigned
  );

  modport master (
    output reqValid, reqStore, reqLoad, reqAddress, reqData, reqLength,
           reqUnsigned, memReadData,
    input  reqReady, respValid, respData, respFault, memAddress,
           memWriteData, memLength, memStore, memLoad, memUnsigned
  );

endinterface

// File: rtl/lsu_sequencer_align_check.sv
// Combinational legality check for one memory request: reserved length,
// ambiguous direction (store and load both or neither) and misalignment.
module lsu_align_check
  import lsu_sequencer_pkg::*;
(
  input  logic [1:0] address,
  input  logic [1:0] length,
  input  logic       store,
  input  logic       load,
  output logic       fault
);

  // any single violation faults the whole request
  always_comb begin
    fault = 1'b0;
    if (len_e'(length) == LEN_RSVD)   fault = 1'b1;
    if (store == load)                fault = 1'b1;
    if (misaligned(address, length))  fault = 1'b1;
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer in front of memoryController. Accepts one request at
// a time, screens it for legality, pulses storeIn for one cycle or holds
// loadIn for READ_LATENCY cycles, then returns a one-cycle response.
module lsu_sequencer
  import lsu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2    // 1..MAX_READ_LATENCY
) (
  input  logic            clk,
  input  logic            reset,    // asynchronous, active low
  lsu_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] RL_CNT = CNT_W'(READ_LATENCY);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  req_ctl_t              hold;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_store;
  logic                  mem_load;
  logic                  resp_valid;
  logic                  resp_fault;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  req_fault;
  logic                  accept;

  lsu_align_check u_align (
    .address (bus.reqAddress[1:0]),
    .length  (bus.reqLength),
    .store   (bus.reqStore),
    .load    (bus.reqLoad),
    .fault   (req_fault)
  );

  // Ready only in IDLE and never while reset is held.
  assign bus.reqReady = (state == IDLE) && reset;
  assign accept       = bus.reqValid && bus.reqReady;

  // Sequencer FSM: every strobe and response field is a flop here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hold       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_store  <= 1'b0;
      mem_load   <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_data  <= '0;
    end else begin
      mem_store  <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // operands move to the memory side on accept, faulting or not
            mem_addr         <= bus.reqAddress;
            mem_wdata        <= bus.reqData;
            hold.length      <= bus.reqLength;
            hold.is_unsigned <= bus.reqUnsigned;
            if (req_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_data  <= '0;
            end else if (bus.reqStore) begin
              state     <= STORE;
              mem_store <= 1'b1;
            end else begin
              state    <= LOAD;
              mem_load <= 1'b1;
              cnt      <= CNT_W'(1);
            end
          end
        end
        STORE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_data  <= '0;
        end
        LOAD: begin
          // the RAM output is valid once loadIn has been held READ_LATENCY cycles
          if (cnt == RL_CNT) begin
            state      <= RESP;
            mem_load   <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_data  <= bus.memReadData;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.memAddress   = mem_addr;
  assign bus.memWriteData = mem_wdata;
  assign bus.memLength    = hold.length;
  assign bus.memUnsigned  = hold.is_unsigned;
  assign bus.memStore     = mem_store;
  assign bus.memLoad      = mem_load;
  assign bus.respValid    = resp_valid;
  assign bus.respFault    = resp_fault;
  assign bus.respData     = resp_data;

  // Strobes are mutually exclusive and silent in IDLE and RESP.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset)
    !(mem_store && mem_load));
  a_strobe_quiet: assert property (@(posedge clk) disable iff (!reset)
    (state == IDLE || state == RESP) |-> !(mem_store || mem_load));

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: a transaction-level model predicts, per cycle,
// strobes, ready, response and operands from each accepted request's accept
// cycle and latency; directed cases pin literal values, then random traffic.
module tb_lsu_sequencer;

  localparam int DW   = 32;
  localparam int RL   = 2;
  localparam int MAXC = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lsu_sequencer_if #(.DATA_WIDTH(DW)) bus();

  lsu_sequencer #(.DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int c     = 0;

  // model state
  bit          in_reset  = 1'b1;
  int          idle_from = 0;
  bit          act       = 1'b0;
  int          a = 0, lat = 0, kind = 0;   // kind: 0 fault, 1 store, 2 load
  logic [31:0] cur_addr = '0, cur_wd = '0, prev_addr = '0, prev_wd = '0;
  logic [1:0]  cur_len = '0, prev_len = '0;
  logic        cur_uns = 1'b0, prev_uns = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        exp_rfault = 1'b0;
  logic [31:0] rd_hist [MAXC];
  bit          accepted;
  bit          rand_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act_v, exp_v, c);
    end
  endtask

  task automatic model_reset();
    in_reset = 1'b1;
    act = 1'b0;
    cur_addr = '0; cur_wd = '0; cur_len = '0; cur_uns = 1'b0;
    prev_addr = '0; prev_wd = '0; prev_len = '0; prev_uns = 1'b0;
    exp_rdata = '0; exp_rfault = 1'b0;
  endtask

  // Record this cycle's read data and decide whether the next edge accepts.
  task automatic commit();
    bit f;
    rd_hist[c % MAXC] = bus.memReadData;
    accepted = 1'b0;
    if (!in_reset && bus.reqValid && c >= idle_from) begin
      f = (bus.reqLength == 2) || (bus.reqStore == bus.reqLoad) ||
          (bus.reqLength == 1 && bus.reqAddress % 2 != 0) ||
          (bus.reqLength == 3 && bus.reqAddress % 4 != 0);
      kind = f ? 0 : (bus.reqStore ? 1 : 2);
      lat  = (kind == 0) ? 1 : (kind == 1) ? 2 : RL + 1;
      a = c + 1;
      idle_from = a + lat;
      act = 1'b1;
      accepted = 1'b1;
      prev_addr = cur_addr; prev_wd = cur_wd; prev_len = cur_len; prev_uns = cur_uns;
      cur_addr = bus.reqAddress; cur_wd = bus.reqData;
      cur_len = bus.reqLength; cur_uns = bus.reqUnsigned;
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_cycle();
    logic        e_rdy, e_st, e_ld, e_rv, e_uns;
    logic [31:0] e_addr, e_wd;
    logic [1:0]  e_len;
    if (in_reset) begin
      e_rdy = 0; e_st = 0; e_ld = 0; e_rv = 0;
      e_addr = '0; e_wd = '0; e_len = '0; e_uns = 0;
    end else begin
      e_rdy = (c >= idle_from);
      e_st  = act && kind == 1 && c == a;
      e_ld  = act && kind == 2 && c >= a && c < a + RL;
      e_rv  = act && c == a + lat - 1;
      if (e_rv) begin
        exp_rdata  = (kind == 2) ? rd_hist[(a + RL - 1) % MAXC] : 32'h0;
        exp_rfault = (kind == 0);
      end
      if (act && c >= a) begin
        e_addr = cur_addr; e_wd = cur_wd; e_len = cur_len; e_uns = cur_uns;
      end else begin
        e_addr = prev_addr; e_wd = prev_wd; e_len = prev_len; e_uns = prev_uns;
      end
    end
    chk("reqReady",     bus.reqReady,     e_rdy);
    chk("memStore",     bus.memStore,     e_st);
    chk("memLoad",      bus.memLoad,      e_ld);
    chk("respValid",    bus.respValid,    e_rv);
    chk("respFault",    bus.respFault,    exp_rfault);
    chk("respData",     bus.respData,     exp_rdata);
    chk("memAddress",   bus.memAddress,   e_addr);
    chk("memWriteData", bus.memWriteData, e_wd);
    chk("memLength",    bus.memLength,    e_len);
    chk("memUnsigned",  bus.memUnsigned,  e_uns);
  endtask

  task automatic tick();
    @(negedge clk);
    c++;
    check_cycle();
  endtask

  task automatic step();
    if (rand_rd) bus.memReadData = $urandom;
    commit();
    tick();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Present a request and step until the model sees it accepted.
  task automatic issue(input logic st, input logic ld, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] len, input logic uns);
    bit done;
    done = 1'b0;
    bus.reqStore = st; bus.reqLoad = ld; bus.reqAddress = addr;
    bus.reqData = data; bus.reqLength = len; bus.reqUnsigned = uns;
    bus.reqValid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (accepted) done = 1'b1;
    end
    bus.reqValid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: got no accept want accept within 40 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, rdy2, acc;
    bus.reqValid = 0; bus.reqStore = 0; bus.reqLoad = 0; bus.reqAddress = '0;
    bus.reqData = '0; bus.reqLength = '0; bus.reqUnsigned = 0; bus.memReadData = '0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("reset_ready", bus.reqReady, 1'b0);
    chk("reset_rdata", bus.respData, 32'h0);
    chk("reset_addr",  bus.memAddress, 32'h0);
    rst_n = 1'b1; in_reset = 1'b0; idle_from = c;
    #1 chk("release_ready", bus.reqReady, 1'b1);

    // word store
    issue(1, 0, 32'h100, 32'hDEADBEEF, 2'd3, 0);
    chk("st_strobe", bus.memStore, 1'b1);
    chk("st_addr",   bus.memAddress, 32'h100);
    chk("st_wdata",  bus.memWriteData, 32'hDEADBEEF);
    step();
    chk("st_strobe_off", bus.memStore, 1'b0);
    chk("st_rv",    bus.respValid, 1'b1);
    chk("st_fault", bus.respFault, 1'b0);
    chk("st_rdata", bus.respData, 32'h0);
    step();

    // signed byte load
    bus.memReadData = 32'hFFFFFF80;
    issue(0, 1, 32'h103, 32'h0, 2'd0, 0);
    chk("ld_strobe1", bus.memLoad, 1'b1);
    chk("ld_uns", bus.memUnsigned, 1'b0);
    step();
    chk("ld_strobe2", bus.memLoad, 1'b1);
    chk("ld_rv_early", bus.respValid, 1'b0);
    step();
    chk("ld_strobe_off", bus.memLoad, 1'b0);
    chk("ld_rv", bus.respValid, 1'b1);
    chk("ld_rdata", bus.respData, 32'hFFFFFF80);
    step();

    // misaligned half load
    issue(0, 1, 32'h101, 32'h0, 2'd1, 0);
    chk("half_rv", bus.respValid, 1'b1);
    chk("half_fault", bus.respFault, 1'b1);
    chk("half_noload", bus.memLoad, 1'b0);
    step();

    // reserved length, then store+load together
    issue(1, 0, 32'h40, 32'h1234, 2'd2, 0);
    chk("len2_fault", bus.respFault, 1'b1);
    chk("len2_nostore", bus.memStore, 1'b0);
    step();
    issue(1, 1, 32'h80, 32'h5, 2'd3, 0);
    chk("both_fault", bus.respFault, 1'b1);
    chk("both_nostore", bus.memStore, 1'b0);
    chk("both_noload", bus.memLoad, 1'b0);
    step();

    // back-to-back stores with reqValid held
    bus.reqStore = 1; bus.reqLoad = 0; bus.reqAddress = 32'h10;
    bus.reqData = 32'hA5; bus.reqLength = 2'd3; bus.reqUnsigned = 0;
    bus.reqValid = 1'b1;
    r1 = -1; rdy2 = -1; acc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (accepted) acc++;
      if (acc == 2) bus.reqValid = 1'b0;
      if (bus.respValid && r1 < 0) begin
        r1 = c;
        chk("b2b_ready_in_resp", bus.reqReady, 1'b0);
      end
      if (r1 >= 0 && c > r1 && bus.reqReady && rdy2 < 0) rdy2 = c;
    end
    bus.reqValid = 1'b0;
    chk("b2b_ready_after_resp", rdy2, r1 + 1);

    // random traffic
    rand_rd = 1'b1;
    for (int n = 0; n < 250; n++) begin
      int r;
      logic [31:0] ad;
      run($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
      issue(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, ad, $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    run(RL + 3);

    // reset in the first LOAD cycle
    rand_rd = 1'b0;
    bus.memReadData = 32'h11223344;
    issue(0, 1, 32'h200, 32'h0, 2'd3, 1);
    chk("pre_rst_load", bus.memLoad, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_load_drop", bus.memLoad, 1'b0);
    chk("async_ready", bus.reqReady, 1'b0);
    chk("async_addr", bus.memAddress, 32'h0);
    model_reset();
    run(4);
    rst_n = 1'b1; in_reset = 1'b0; idle_from = c;
    #1 chk("rst_rel_ready", bus.reqReady, 1'b1);
    bus.memReadData = 32'hCAFEF00D;
    issue(0, 1, 32'h204, 32'h0, 2'd3, 0);
    run(2);
    chk("post_rst_rv", bus.respValid, 1'b1);
    chk("post_rst_rdata", bus.respData, 32'hCAFEF00D);
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
